// File: rtl/yuv422_video_capture.sv
// yuv422_video_capture: rebuild 24-bit {Y,Cb,Cr} pixels from a 16-bit 4:2:2 stream and write them to a framebuffer
//   clk_i, rst_i       pixel clock, asynchronous active-high reset
//   vs_i, ad_i         vertical sync (rising edge = frame start), active-data flag
//   hdmi_d_i           [15:8]=Y, [7:0]=Cb on even x / Cr on odd x
//   err_clr_i          synchronous clear of the sticky error flags
//   pxl_addr_o/data_o  framebuffer write address and {Y,Cb,Cr} data, held while pxl_en_o=0
//   pxl_en_o           one-cycle write strobe per written pixel
//   frame_start_o      pulse on each accepted vs rise
//   lock_o             LOCK_FRAMES consecutive good frames seen
//   line_err_o         sticky: an active line had the wrong length
//   frame_err_o        sticky: a frame had the wrong active line count
module yuv422_video_capture #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES = 720,
  parameter int FRAME_X_SCALE = 0,
  parameter int FRAME_Y_SCALE = 0,
  parameter int LOCK_FRAMES = 2,
  localparam int FB_X = ACTIVE_H_PIXELS >> FRAME_X_SCALE,
  localparam int FB_Y = ACTIVE_LINES >> FRAME_Y_SCALE,
  localparam int FB_ADDR_BITS = $clog2(FB_X * FB_Y)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vs_i,
  input  logic ad_i,
  input  logic [15:0] hdmi_d_i,
  input  logic err_clr_i,
  output logic [FB_ADDR_BITS-1:0] pxl_addr_o,
  output logic [23:0] pxl_data_o,
  output logic pxl_en_o,
  output logic frame_start_o,
  output logic lock_o,
  output logic line_err_o,
  output logic frame_err_o
);
  localparam logic [15:0] H = 16'(ACTIVE_H_PIXELS);
  localparam logic [15:0] L = 16'(ACTIVE_LINES);
  localparam logic [15:0] XM = 16'((1 << FRAME_X_SCALE) - 1);
  localparam logic [15:0] YM = 16'((1 << FRAME_Y_SCALE) - 1);
  localparam logic [3:0] LK = 4'(LOCK_FRAMES);
  typedef enum logic {SEEK, CAPTURE} state_t;
  state_t state, state_nx;
  logic vs_r, vs_q, ad_r, ad_q, skip, fl_err;
  logic [15:0] d_r, x, y;
  logic [7:0] cb, cbv, cr;
  logic [3:0] good;
  logic vs_rise, ad_fall, cap, pix, wr, lchk, lbad, fchk, fgood;
  logic [FB_ADDR_BITS-1:0] addr;
  always_comb begin
    vs_rise = vs_r & ~vs_q;
    ad_fall = ad_q & ~ad_r;
    cap = state == CAPTURE;
    // skip marks the tail of a line cut by a vs rise: not counted, written or checked
    pix = ad_r & ~skip & cap;
    wr = pix & (x < H) & (y < L) & ((x & XM) == 16'd0) & ((y & YM) == 16'd0);
    lchk = cap & ad_fall & ~skip & ~vs_rise;
    lbad = lchk & (x != H);
    fchk = cap & vs_rise;
    fgood = (y == L) & ~fl_err;
    addr = FB_ADDR_BITS'(32'(y >> FRAME_Y_SCALE) * 32'(FB_X) + 32'(x >> FRAME_X_SCALE));
    // an even pixel borrows Cr from its odd partner, still on the raw input; no partner means neutral chroma
    cbv = x[0] ? cb : d_r[7:0];
    cr = x[0] ? d_r[7:0] : (ad_i ? hdmi_d_i[7:0] : 8'h80);
    state_nx = (state == SEEK && vs_rise) ? CAPTURE : state;
  end
  assign lock_o = good == LK;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= SEEK;
      {vs_r, vs_q, ad_r, ad_q, skip, fl_err} <= '0;
      {d_r, x, y, cb, good} <= '0;
      {pxl_addr_o, pxl_data_o, pxl_en_o, frame_start_o, line_err_o, frame_err_o} <= '0;
    end else begin
      state <= state_nx;
      {vs_r, vs_q, ad_r, ad_q} <= {vs_i, vs_r, ad_i, ad_r};
      d_r <= hdmi_d_i;
      x <= (vs_rise | ad_fall) ? 16'd0 : (pix & x != 16'hffff) ? x + 16'd1 : x;
      y <= vs_rise ? 16'd0 : (lchk & x != 16'd0 & y != 16'hffff) ? y + 16'd1 : y;
      skip <= vs_rise ? ad_r : ad_fall ? 1'b0 : skip;
      fl_err <= vs_rise ? 1'b0 : (fl_err | lbad);
      if (pix & ~x[0]) cb <= d_r[7:0];
      if (fchk) good <= fgood ? (good == LK ? good : good + 4'd1) : 4'd0;
      frame_start_o <= vs_rise;
      line_err_o <= lbad | (line_err_o & ~err_clr_i);
      frame_err_o <= (fchk & (y != L)) | (frame_err_o & ~err_clr_i);
      pxl_en_o <= wr;
      if (wr) begin
        pxl_addr_o <= addr;
        pxl_data_o <= {d_r[15:8], cbv, cr};
      end
    end
  end
endmodule

// File: tb/tb_yuv422_video_capture.sv
// tb_yuv422_video_capture: directed checks of capture, pairing, gating, geometry check and decimation
module tb_yuv422_video_capture;
  logic clk = 0, rst_i = 1, vs_i = 0, ad_i = 0, err_clr_i = 0;
  logic [15:0] hdmi_d_i = '0;
  logic [4:0] addr_a;
  logic [2:0] addr_b;
  logic [23:0] data_a, data_b;
  logic en_a, en_b, fs_a, fs_b, lock_a, lock_b, lerr_a, lerr_b, ferr_a, ferr_b;
  int cyc = 0, n_vec = 0, n_bad = 0, fs_n = 0;
  int wa_c[$];
  logic [4:0] wa_a[$];
  logic [23:0] wa_d[$];
  logic [2:0] wb_a[$];
  logic [23:0] wb_d[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  yuv422_video_capture #(.ACTIVE_H_PIXELS(8), .ACTIVE_LINES(4), .FRAME_X_SCALE(0), .FRAME_Y_SCALE(0), .LOCK_FRAMES(2)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .vs_i(vs_i), .ad_i(ad_i), .hdmi_d_i(hdmi_d_i), .err_clr_i(err_clr_i),
    .pxl_addr_o(addr_a), .pxl_data_o(data_a), .pxl_en_o(en_a), .frame_start_o(fs_a),
    .lock_o(lock_a), .line_err_o(lerr_a), .frame_err_o(ferr_a));
  yuv422_video_capture #(.ACTIVE_H_PIXELS(8), .ACTIVE_LINES(4), .FRAME_X_SCALE(1), .FRAME_Y_SCALE(1), .LOCK_FRAMES(2)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .vs_i(vs_i), .ad_i(ad_i), .hdmi_d_i(hdmi_d_i), .err_clr_i(err_clr_i),
    .pxl_addr_o(addr_b), .pxl_data_o(data_b), .pxl_en_o(en_b), .frame_start_o(fs_b),
    .lock_o(lock_b), .line_err_o(lerr_b), .frame_err_o(ferr_b));
  always @(negedge clk) begin
    if (en_a) begin
      wa_c.push_back(cyc);
      wa_a.push_back(addr_a);
      wa_d.push_back(data_a);
    end
    if (en_b) begin
      wb_a.push_back(addr_b);
      wb_d.push_back(data_b);
    end
    if (fs_a) fs_n++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive_px(input int ln, input int i);
    hdmi_d_i = {8'h10 + 8'(16 * ln + i), i % 2 ? 8'hC0 : 8'h40};
    ad_i = 1;
  endtask
  task automatic line(input int n, input int ln);
    for (int i = 0; i < n; i++) begin
      drive_px(ln, i);
      tick;
    end
    ad_i = 0;
    repeat (4) tick;
  endtask
  task automatic vs_pulse;
    vs_i = 1;
    tick;
    tick;
    vs_i = 0;
    repeat (3) tick;
  endtask
  task automatic err_clr;
    err_clr_i = 1;
    tick;
    err_clr_i = 0;
    tick;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_en"}, en_a, 0);
    chk({tag, "_addr"}, addr_a, 0);
    chk({tag, "_data"}, data_a, 0);
    chk({tag, "_fs"}, fs_a, 0);
    chk({tag, "_lock"}, lock_a, 0);
    chk({tag, "_lerr"}, lerr_a, 0);
    chk({tag, "_ferr"}, ferr_a, 0);
  endtask
  initial begin
    int s, sb, c0, f0;
    repeat (3) tick;
    all_zero("reset");
    rst_i = 0;
    tick;
    line(8, 0);
    chk("pre_vs_writes", wa_c.size(), 0);
    s = wa_c.size();
    f0 = fs_n;
    vs_pulse;
    chk("fs_once", fs_n - f0, 1);
    c0 = cyc;
    line(8, 0);
    chk("line0_count", wa_c.size() - s, 8);
    chk("line0_first_cyc", wa_c[s], c0 + 2);
    chk("line0_last_cyc", wa_c[s + 7], c0 + 9);
    for (int k = 0; k < 8; k++) begin
      chk("line0_addr", wa_a[s + k], k);
      chk("line0_data", wa_d[s + k], {8'h10 + 8'(k), 8'h40, 8'hC0});
    end
    for (int l = 1; l < 4; l++) line(8, l);
    vs_pulse;
    chk("v2_lock", lock_a, 0);
    for (int l = 0; l < 4; l++) line(8, l);
    vs_pulse;
    chk("v3_lock", lock_a, 1);
    chk("v3_lerr", lerr_a, 0);
    chk("v3_ferr", ferr_a, 0);
    line(6, 0);
    chk("short_lerr", lerr_a, 1);
    for (int l = 1; l < 4; l++) line(8, l);
    vs_pulse;
    chk("short_lock", lock_a, 0);
    chk("short_ferr", ferr_a, 0);
    err_clr;
    chk("clr_lerr", lerr_a, 0);
    s = wa_c.size();
    for (int l = 0; l < 5; l++) line(8, l);
    chk("five_lines_writes", wa_c.size() - s, 32);
    vs_pulse;
    chk("five_lines_ferr", ferr_a, 1);
    chk("five_lines_lock", lock_a, 0);
    err_clr;
    chk("clr_ferr", ferr_a, 0);
    s = wa_c.size();
    line(7, 0);
    chk("odd_count", wa_c.size() - s, 7);
    chk("odd_px5_data", wa_d[s + 5], 24'h1540C0);
    chk("odd_last_addr", wa_a[s + 6], 6);
    chk("odd_last_data", wa_d[s + 6], 24'h164080);
    chk("odd_lerr", lerr_a, 1);
    for (int l = 1; l < 4; l++) line(8, l);
    err_clr;
    vs_pulse;
    sb = wb_a.size();
    for (int l = 0; l < 4; l++) line(8, l);
    chk("scale_count", wb_a.size() - sb, 8);
    for (int k = 0; k < 8; k++) chk("scale_addr", wb_a[sb + k], k);
    chk("scale_data0", wb_d[sb], 24'h1040C0);
    chk("scale_data5", wb_d[sb + 5], 24'h3240C0);
    vs_pulse;
    for (int i = 0; i < 3; i++) begin
      drive_px(0, i);
      tick;
    end
    chk("pre_rst_en", en_a, 1);
    #2;
    rst_i = 1;
    s = wa_c.size();
    #1;
    all_zero("async_rst");
    tick;
    rst_i = 0;
    for (int i = 3; i < 8; i++) begin
      drive_px(0, i);
      tick;
    end
    ad_i = 0;
    repeat (4) tick;
    line(8, 1);
    chk("post_rst_writes", wa_c.size() - s, 0);
    f0 = fs_n;
    vs_pulse;
    line(8, 0);
    chk("resume_fs", fs_n - f0, 1);
    chk("resume_count", wa_c.size() - s, 8);
    chk("resume_addr", wa_a[s], 0);
    chk("resume_data", wa_d[s], 24'h1040C0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/yuv422_video_capture.md
Name: yuv422_video_capture

Overview:
- Receive-side counterpart of the ADV7511 output path.
- Accepts a 16-bit YCbCr 4:2:2 video stream (vs/hs-style sync plus active-data flag) and rebuilds 24-bit {Y,Cb,Cr} pixels.
- Computes framebuffer addresses, with optional power-of-two decimation, and drives a framebuffer write port with the same addr/data/en shape as the display framebuffer.
- Checks the incoming frame geometry against the parameters and reports lock and errors. Used for loopback verification and video capture.

Parameters:
- ACTIVE_H_PIXELS, 1280, expected active pixels per line (even).
- ACTIVE_LINES, 720, expected active lines per frame.
- FRAME_X_SCALE, 0, horizontal decimation is 2^FRAME_X_SCALE.
- FRAME_Y_SCALE, 0, vertical decimation is 2^FRAME_Y_SCALE.
- LOCK_FRAMES, 2, consecutive good frames required to assert lock_o (1..15).
- FB_X (local), ACTIVE_H_PIXELS>>FRAME_X_SCALE.
- FB_Y (local), ACTIVE_LINES>>FRAME_Y_SCALE.
- FB_ADDR_BITS (local), $clog2(FB_X*FB_Y).

Ports:
- clk_i  in  1  pixel-domain clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- vs_i  in  1  vertical sync, active high; its rising edge marks frame start.
- ad_i  in  1  active data; high for every valid pixel cycle.
- hdmi_d_i  in  16  [15:8]=Y; [7:0]=Cb on even x, Cr on odd x.
- err_clr_i  in  1  synchronous clear of the sticky error flags.
- pxl_addr_o  out  FB_ADDR_BITS  framebuffer write address.
- pxl_data_o  out  24  {Y,Cb,Cr}.
- pxl_en_o  out  1  write strobe, one cycle per written pixel.
- frame_start_o  out  1  single-cycle pulse on each accepted vs_i rising edge.
- lock_o  out  1  geometry locked.
- line_err_o  out  1  sticky: an active line length differed from ACTIVE_H_PIXELS.
- frame_err_o  out  1  sticky: active line count differed from ACTIVE_LINES.

Behaviour:
- Reset: every output is 0; the state machine enters SEEK; all counters, the chroma hold registers and the good-frame counter are 0.
- vs_i and ad_i are registered once internally. Edges are detected on the registered copies.
- State machine:
  - SEEK: ignore data and assert no writes. On vs rise, pulse frame_start_o and go to CAPTURE.
  - CAPTURE: on each vs rise, run the frame check, pulse frame_start_o, and reset y and the line counter.
  - There is no other exit from CAPTURE except reset.
- Pixel counter x: counts ad_i-high cycles, clears on the ad fall.
  - On the ad fall: if x != ACTIVE_H_PIXELS, set line_err_o. Increment y if x > 0.
- Chroma pairing:
  - An even-x pixel holds its Y and Cb.
  - At the next odd-x cycle, the even pixel is emitted as {Y_even, Cb, Cr_odd} and the odd pixel as {Y_odd, Cb, Cr_odd}.
  - If ad falls after an even pixel with no odd partner, that pixel is emitted with Cr=8'h80.
- Latency: every pixel appears on pxl_* exactly 2 cycles after its input cycle. Order is preserved and there are no gaps during an active run.
- Write gating: pxl_en_o=1 only when all of these hold:
  - the state is CAPTURE;
  - x < ACTIVE_H_PIXELS and y < ACTIVE_LINES;
  - x[FRAME_X_SCALE-1:0]==0 and y[FRAME_Y_SCALE-1:0]==0 (no check when the scale is 0).
- Address: pxl_addr_o = (y>>FRAME_Y_SCALE)*FB_X + (x>>FRAME_X_SCALE), computed in a width wide enough to avoid overflow, then truncated to FB_ADDR_BITS. Out-of-range pixels are never written.
- pxl_addr_o and pxl_data_o hold their last value when pxl_en_o=0.
- Frame check on a vs rise in CAPTURE:
  - The frame is good if the line count == ACTIVE_LINES and no line error occurred in that frame.
  - A bad frame sets frame_err_o (line-count mismatch only), clears the good counter and drops lock_o.
  - A good frame increments the good counter, saturating at LOCK_FRAMES. lock_o=1 while the counter == LOCK_FRAMES.
  - The first vs rise after SEEK performs no check.
- vs rise during an active run: the partial line is aborted.
  - Pixels already in the pipeline still emit.
  - No line check is made for the aborted line; y resets to 0.
- err_clr_i clears line_err_o and frame_err_o. A simultaneous set wins over the clear.
- Async reset mid-frame: all outputs are 0 immediately; capture restarts in SEEK.

Test Plan:
- Common bench parameters: ACTIVE_H_PIXELS=8, ACTIVE_LINES=4, scale 0/0, LOCK_FRAMES=2.
- Reset, then one vs pulse, then line 0 data Y=0x10..0x17 with Cb=0x40 (even x) and Cr=0xC0 (odd x) -> 8 writes at addr 0..7, each data {Y,0x40,0xC0}, first write 2 cycles after the first ad cycle; frame_start_o pulses once.
- Data before the first vs -> pxl_en_o stays 0. Then 3 correct frames -> lock_o rises at the 3rd vs rise (2 checked good frames); line_err_o=frame_err_o=0.
- After lock, one line of 6 pixels -> line_err_o=1 immediately after the ad fall. At the next vs, lock_o=0 and frame_err_o stays 0. Pulse err_clr_i -> line_err_o=0.
- A frame with 5 active lines -> line 4 is not written, frame_err_o=1 at the next vs, lock_o=0.
- A line of 7 pixels (odd length) -> the 7th pixel is written with Cr=0x80 at addr 6, and line_err_o=1.
- With FRAME_X_SCALE=1 and FRAME_Y_SCALE=1 (FB 4x2), a full frame -> 8 writes, addresses 0..7 in order, taken from even x on lines 0 and 2 only.
- Assert rst_i mid-line -> all outputs are 0 in the same cycle; no write occurs until the next vs rise.
